// File: rtl/fwd_hazard_unit_pkg.sv
// Shared constants for the forwarding/hazard unit and the EX-stage operand muxes.
package fwd_hazard_unit_pkg;

  localparam int REG_W_DEF = 5;

  localparam logic [1:0] SEL_ALUSRC_REG = 2'b00;
  localparam logic [1:0] SEL_ALUSRC_IMM = 2'b01;
  localparam logic [1:0] SEL_ALUSRC_EX  = 2'b10;
  localparam logic [1:0] SEL_ALUSRC_WB  = 2'b11;

  localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/fwd_hazard_unit_match.sv
// fwd_match: does a source operand read the destination of a live-writer slot.
module fwd_match
  import fwd_hazard_unit_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] src,
  input  logic             use_src,
  input  logic             slot_vld,
  input  logic [REG_W-1:0] slot_dest,
  input  logic             slot_we,
  output logic             match
);

  // $0 is hardwired to zero, so a slot writing it is never a producer.
  assign match = use_src && slot_vld && slot_we && (slot_dest != '0) && (src == slot_dest);

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select generation and load-use stall detection for the ID/EX boundary.
// Build option FWD_FORWARDING_EN: enables EX/WB forwarding; without it every RAW hazard stalls.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_alusrc_imm,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_we,
  input  logic             id_is_load,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       ex_sel_a,
  output logic [1:0]       ex_sel_b,
  output logic [31:0]      stall_cnt
);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == STALL_CNT_MAX) ? v : v + 32'd1;
  endfunction

  logic             vld_p1, we_p1, load_p1;
  logic [REG_W-1:0] dest_p1;
  logic             vld_p2, we_p2;
  logic [REG_W-1:0] dest_p2;

  logic       a_ex, a_mem, b_ex, b_mem;
  logic       use_b_p0;
  logic       load_use_p0, hazard_p0, advance_p0;
  logic [1:0] sel_a_p0, sel_b_p0;
  logic [1:0] sel_a_p1, sel_b_p1;

  // ---- ID stage: match sources against EX (p1) and MEM (p2) slots ----
  assign use_b_p0 = id_use_rt && !id_alusrc_imm;

  fwd_match #(.REG_W(REG_W)) u_match_a_ex (
    .src(id_rs), .use_src(id_use_rs), .slot_vld(vld_p1), .slot_dest(dest_p1),
    .slot_we(we_p1), .match(a_ex)
  );
  fwd_match #(.REG_W(REG_W)) u_match_a_mem (
    .src(id_rs), .use_src(id_use_rs), .slot_vld(vld_p2), .slot_dest(dest_p2),
    .slot_we(we_p2), .match(a_mem)
  );
  fwd_match #(.REG_W(REG_W)) u_match_b_ex (
    .src(id_rt), .use_src(use_b_p0), .slot_vld(vld_p1), .slot_dest(dest_p1),
    .slot_we(we_p1), .match(b_ex)
  );
  fwd_match #(.REG_W(REG_W)) u_match_b_mem (
    .src(id_rt), .use_src(use_b_p0), .slot_vld(vld_p2), .slot_dest(dest_p2),
    .slot_we(we_p2), .match(b_mem)
  );

  assign load_use_p0 = (a_ex || b_ex) && load_p1;

  always_comb begin
    sel_a_p0  = SEL_ALUSRC_REG;
    sel_b_p0  = SEL_ALUSRC_REG;
    hazard_p0 = load_use_p0;
`ifdef FWD_FORWARDING_EN
    // EX slot holds the youngest producer, so it outranks MEM.
    if (a_ex)       sel_a_p0 = SEL_ALUSRC_EX;
    else if (a_mem) sel_a_p0 = SEL_ALUSRC_WB;
    if (id_alusrc_imm) sel_b_p0 = SEL_ALUSRC_IMM;
    else if (b_ex)     sel_b_p0 = SEL_ALUSRC_EX;
    else if (b_mem)    sel_b_p0 = SEL_ALUSRC_WB;
`else
    if (id_alusrc_imm) sel_b_p0 = SEL_ALUSRC_IMM;
    hazard_p0 = load_use_p0 || a_ex || a_mem || b_ex || b_mem;
`endif
  end

  // A redirect kills the ID instruction, so it can never stall.
  assign stall      = id_valid && !flush && hazard_p0;
  assign advance_p0 = !flush && !stall;

  // ---- ID/EX and EX/MEM boundary: control (reset) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      sel_a_p1  <= SEL_ALUSRC_REG;
      sel_b_p1  <= SEL_ALUSRC_REG;
      stall_cnt <= '0;
    end else begin
      vld_p2   <= vld_p1;
      vld_p1   <= advance_p0 && id_valid;
      sel_a_p1 <= advance_p0 ? sel_a_p0 : SEL_ALUSRC_REG;
      sel_b_p1 <= advance_p0 ? sel_b_p0 : SEL_ALUSRC_REG;
      if (stall) stall_cnt <= sat_inc(stall_cnt);
    end
  end

  // ---- ID/EX and EX/MEM boundary: slot payload, qualified by vld_pN ----
  always_ff @(posedge clk) begin
    dest_p2 <= dest_p1;
    we_p2   <= we_p1;
    dest_p1 <= id_dest;
    we_p1   <= id_we;
    load_p1 <= id_is_load;
  end

  assign ex_sel_a = sel_a_p1;
  assign ex_sel_b = sel_b_p1;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed pipeline scenarios plus randomized traffic vs. a reference model.
module tb_fwd_hazard_unit;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       id_use_rs, id_use_rt, id_alusrc_imm, id_we, id_is_load, flush;
  logic       stall;
  logic [1:0] ex_sel_a, ex_sel_b;
  logic [31:0] stall_cnt;

  fwd_hazard_unit #(.REG_W(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_alusrc_imm(id_alusrc_imm),
    .id_dest(id_dest), .id_we(id_we), .id_is_load(id_is_load), .flush(flush),
    .stall(stall), .ex_sel_a(ex_sel_a), .ex_sel_b(ex_sel_b), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a two-entry list of in-flight instructions, index 0 = youngest (EX).
  typedef struct packed {
    logic       v;
    logic [4:0] d;
    logic       we;
    logic       ld;
  } slot_t;

  slot_t       pipe [2];
  logic [1:0]  m_sel_a, m_sel_b, nx_sel_a, nx_sel_b;
  logic [31:0] m_cnt;
  logic        m_stall;

  function automatic int producer(input logic [4:0] r);
    for (int i = 0; i < 2; i++)
      if (pipe[i].v && pipe[i].we && pipe[i].d != 5'd0 && pipe[i].d == r) return i;
    return -1;
  endfunction

  function automatic logic [1:0] code_of(input int p);
    if (p == 0) return 2'b10;
    if (p == 1) return 2'b11;
    return 2'b00;
  endfunction

  task automatic model_eval();
    int pa, pb;
    pa = id_use_rs ? producer(id_rs) : -1;
    pb = (id_use_rt && !id_alusrc_imm) ? producer(id_rt) : -1;
`ifdef FWD_FORWARDING_EN
    m_stall  = id_valid && !flush && (pa == 0 || pb == 0) && pipe[0].ld;
    nx_sel_a = code_of(pa);
    nx_sel_b = id_alusrc_imm ? 2'b01 : code_of(pb);
`else
    m_stall  = id_valid && !flush && (pa >= 0 || pb >= 0);
    nx_sel_a = 2'b00;
    nx_sel_b = id_alusrc_imm ? 2'b01 : 2'b00;
`endif
  endtask

  task automatic model_reset();
    pipe[0] = '0;
    pipe[1] = '0;
    m_sel_a = 2'b00;
    m_sel_b = 2'b00;
    m_cnt   = 32'd0;
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
    end else begin
      pipe[1] = pipe[0];
      if (flush || m_stall) begin
        pipe[0] = '0;
        m_sel_a = 2'b00;
        m_sel_b = 2'b00;
      end else begin
        pipe[0] = '{v: id_valid, d: id_dest, we: id_we, ld: id_is_load};
        m_sel_a = nx_sel_a;
        m_sel_b = nx_sel_b;
      end
      if (m_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    end
  endtask

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic cycle();
    #2;
    model_eval();
    chk("stall", {31'd0, stall}, {31'd0, m_stall});
    model_step();
    @(posedge clk);
    #1;
    chk("sel_a", {30'd0, ex_sel_a}, {30'd0, m_sel_a});
    chk("sel_b", {30'd0, ex_sel_b}, {30'd0, m_sel_b});
    chk("stall_cnt", stall_cnt, m_cnt);
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic imm,
                       input logic [4:0] dest, input logic we, input logic ld, input logic fl);
    id_valid = v;   id_rs = rs;   id_rt = rt;   id_use_rs = urs; id_use_rt = urt;
    id_alusrc_imm = imm; id_dest = dest; id_we = we; id_is_load = ld; flush = fl;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk("rst_sel_a", {30'd0, ex_sel_a}, 32'd0);
    chk("rst_sel_b", {30'd0, ex_sel_b}, 32'd0);
    chk("rst_cnt", stall_cnt, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic hold;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    m_stall = 1'b0;
    #1;
    do_reset();

`ifdef FWD_FORWARDING_EN
    // EX forwarding: add $3,$1,$2 ; sub $4,$3,$5
    drive(1, 1, 2, 1, 1, 0, 3, 1, 0, 0); cycle();
    drive(1, 3, 5, 1, 1, 0, 4, 1, 0, 0); #1 chk("exf_stall", {31'd0, stall}, 32'd0); cycle();
    chk("exf_sel_a", {30'd0, ex_sel_a}, 32'd2);
    chk("exf_sel_b", {30'd0, ex_sel_b}, 32'd0);
    // MEM forwarding: add $3 ; nop ; or $6,$7,$3
    drive(1, 1, 2, 1, 1, 0, 3, 1, 0, 0); cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
    drive(1, 7, 3, 1, 1, 0, 6, 1, 0, 0); cycle();
    chk("memf_sel_b", {30'd0, ex_sel_b}, 32'd3);
    chk("memf_sel_a", {30'd0, ex_sel_a}, 32'd0);
    // Load-use: lw $8,0($1) ; add $9,$8,$8
    do_reset();
    drive(1, 1, 8, 1, 0, 1, 8, 1, 1, 0); cycle();
    drive(1, 8, 8, 1, 1, 0, 9, 1, 0, 0); #1 chk("lu_stall", {31'd0, stall}, 32'd1); cycle();
    #1 chk("lu_stall_end", {31'd0, stall}, 32'd0); cycle();
    chk("lu_sel_a", {30'd0, ex_sel_a}, 32'd3);
    chk("lu_sel_b", {30'd0, ex_sel_b}, 32'd3);
    chk("lu_cnt", stall_cnt, 32'd1);
`else
    // No forwarding: add $3,$1,$2 ; sub $4,$3,$5 stalls until add leaves MEM
    drive(1, 1, 2, 1, 1, 0, 3, 1, 0, 0); cycle();
    drive(1, 3, 5, 1, 1, 0, 4, 1, 0, 0); #1 chk("nf_stall0", {31'd0, stall}, 32'd1); cycle();
    #1 chk("nf_stall1", {31'd0, stall}, 32'd1); cycle();
    #1 chk("nf_stall2", {31'd0, stall}, 32'd0); cycle();
    chk("nf_sel_a", {30'd0, ex_sel_a}, 32'd0);
    chk("nf_cnt", stall_cnt, 32'd2);
`endif

    // $0 and immediate: addi $0,$1,k ; addi $5,$0,4
    do_reset();
    drive(1, 1, 0, 1, 0, 1, 0, 1, 0, 0); cycle();
    drive(1, 0, 5, 1, 0, 1, 5, 1, 0, 0); #1 chk("zero_stall", {31'd0, stall}, 32'd0); cycle();
    chk("zero_sel_a", {30'd0, ex_sel_a}, 32'd0);
    chk("zero_sel_b", {30'd0, ex_sel_b}, 32'd1);

    // Flush together with a load-use hazard, then prove EX holds a bubble
    do_reset();
    drive(1, 1, 8, 1, 0, 1, 8, 1, 1, 0); cycle();
    drive(1, 8, 8, 1, 1, 0, 9, 1, 0, 1); #1 chk("flush_stall", {31'd0, stall}, 32'd0); cycle();
    chk("flush_sel_a", {30'd0, ex_sel_a}, 32'd0);
    chk("flush_sel_b", {30'd0, ex_sel_b}, 32'd0);
    drive(1, 9, 0, 1, 0, 0, 10, 1, 0, 0); #1 chk("flush_ex_empty", {31'd0, stall}, 32'd0); cycle();
    chk("flush_ex_sel", {30'd0, ex_sel_a}, 32'd0);

    // Reset while stalled: stall must drop right after the reset edge
    do_reset();
    drive(1, 1, 3, 1, 0, 1, 3, 1, 1, 0); cycle();
    drive(1, 3, 0, 1, 0, 0, 4, 1, 0, 0); #1 chk("rststall_pre", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1 chk("rststall_post", {31'd0, stall}, 32'd0);
    chk("rststall_cnt", stall_cnt, 32'd0);

    // Randomized traffic; a stalled instruction is held in ID like real IF/ID would.
    do_reset();
    hold = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (!hold) begin
        drive($urandom_range(0, 7) != 0,
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 3) == 0,
              5'($urandom_range(0, 7)), $urandom_range(0, 4) != 0,
              $urandom_range(0, 2) == 0, 1'b0);
      end
      flush = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 59) == 0);
      cycle();
      hold = m_stall && !rst;
      rst  = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
